alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 128 ++++++++++++
 tb/tb_alu_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a registered 2-bit-opcode ALU.
// Optional per-requester grant counters are enabled by defining ALU_ARB_STATS_EN.
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             res_valid,
  output logic             res_id
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]       gnt_cnt0,
  output logic [7:0]       gnt_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [1:0] {OP_AND, OP_OR, OP_XOR, OP_ADD} op_t;

  state_t           state;
  logic             last_gnt;
  logic             lat_id;
  op_t              lat_op;
  logic [WIDTH-1:0] lat_a;
  logic [WIDTH-1:0] lat_b;

  logic             pick;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic [WIDTH:0]   sum;

  // Contention goes to whoever was not granted last; a lone request always wins.
  always_comb begin
    pick = (req0 && req1) ? ~last_gnt : req1;
  end

  always_comb begin
    sum   = {1'b0, lat_a} + {1'b0, lat_b};
    alu_r = '0;
    alu_c = 1'b0;
    case (lat_op)
      OP_AND: alu_r = lat_a & lat_b;
      OP_OR:  alu_r = lat_a | lat_b;
      OP_XOR: alu_r = lat_a ^ lat_b;
      OP_ADD: begin
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
      end
      default: alu_r = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      res_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      res_id    <= 1'b0;
      last_gnt  <= 1'b1;
      lat_id    <= 1'b0;
      lat_op    <= OP_AND;
      lat_a     <= '0;
      lat_b     <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt0     <= ~pick;
            gnt1     <= pick;
            last_gnt <= pick;
            lat_id   <= pick;
            lat_op   <= op_t'(pick ? op1 : op0);
            lat_a    <= pick ? a1 : a0;
            lat_b    <= pick ? b1 : b0;
            state    <= EXEC;
          end
        end
        EXEC: begin
          result    <= alu_r;
          carry     <= alu_c;
          res_id    <= lat_id;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Counts follow the registered grant pulse, so they lag the grant by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (gnt0 && gnt_cnt0 != 8'hFF) gnt_cnt0 <= gnt_cnt0 + 8'd1;
      if (gnt1 && gnt_cnt1 != 8'hFF) gnt_cnt1 <= gnt_cnt1 + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, scoreboard of expected results,
// hand sequences for contention, backpressure and mid-operation reset.
`timescale 1ns/1ps
module tb_alu_arbiter;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0, res_ready = 1'b0;
  logic [1:0]   op0 = '0, op1 = '0;
  logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic         gnt0, gnt1, carry, res_valid, res_id;
  logic [W-1:0] result;
`ifdef ALU_ARB_STATS_EN
  logic [7:0]   gnt_cnt0, gnt_cnt1;
`endif

  int n_checks = 0;
  int n_fail = 0;

  alu_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .res_ready(res_ready), .result(result),
    .carry(carry), .res_valid(res_valid), .res_id(res_id)
`ifdef ALU_ARB_STATS_EN
    , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {bit id; logic [W-1:0] r; bit c;} exp_t;
  typedef struct {bit id; logic [1:0] op; logic [W-1:0] a; logic [W-1:0] b;
                  int unsigned dly; logic [W-1:0] r; bit c;} vec_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input bit id, input logic [1:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] s;
    e.id = id;
    e.c  = 1'b0;
    s    = {1'b0, a} + {1'b0, b};
    case (op)
      2'd0: e.r = a & b;
      2'd1: e.r = a | b;
      2'd2: e.r = a ^ b;
      default: begin e.r = s[W-1:0]; e.c = s[W]; end
    endcase
    return e;
  endfunction

  // Scoreboard: pop one expected entry per accepted result.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb.size() == 0) check("sb_unexpected", 32'(1), 32'(0));
      else begin
        exp_t e;
        e = sb.pop_front();
        check("res_id", 32'(res_id), 32'(e.id));
        check("result", 32'(result), 32'(e.r));
        check("carry", 32'(carry), 32'(e.c));
      end
    end
  end

  always @(negedge clk) begin
    if (gnt0 || gnt1) check("gnt_mutex", 32'(gnt0 & gnt1), 32'(0));
  end

  task automatic set_req(input bit id, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
    if (id) begin op1 = op; a1 = a; b1 = b; req1 = 1'b1; end
    else    begin op0 = op; a0 = a; b0 = b; req0 = 1'b1; end
  endtask

  task automatic wait_gnt(input bit exp_id);
    bit got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk); #1;
      if (gnt0 || gnt1) got = 1'b1;
    end
    check("gnt_seen", 32'(got), 32'(1));
    if (got) check("gnt_id", 32'(gnt1), 32'(exp_id));
  endtask

  task automatic apply(input bit id, input logic [1:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int unsigned dly,
                       input logic [W-1:0] er, input bit ec);
    @(posedge clk); #1;
    set_req(id, op, a, b);
    res_ready = (dly == 0);
    sb.push_back('{id: id, r: er, c: ec});
    wait_gnt(id);
    if (id) req1 = 1'b0; else req0 = 1'b0;
    @(posedge clk); #1;
    check("latency_valid", 32'(res_valid), 32'(1));
    check("gnt_one_cycle", 32'(gnt0 | gnt1), 32'(0));
    repeat (dly) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(res_valid), 32'(1));
      check("hold_result", 32'(result), 32'(er));
      check("hold_no_gnt", 32'(gnt0 | gnt1), 32'(0));
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("return_idle", 32'(res_valid), 32'(0));
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", 32'(sb.size()), 32'(0));
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{id: 0, op: 2'd3, a: 4'hF, b: 4'h1, dly: 0, r: 4'h0, c: 1'b1};
    vecs[1] = '{id: 1, op: 2'd2, a: 4'hA, b: 4'h5, dly: 5, r: 4'hF, c: 1'b0};
    vecs[2] = '{id: 0, op: 2'd0, a: 4'hC, b: 4'hA, dly: 0, r: 4'h8, c: 1'b0};
    vecs[3] = '{id: 1, op: 2'd1, a: 4'hC, b: 4'h3, dly: 1, r: 4'hF, c: 1'b0};
    vecs[4] = '{id: 0, op: 2'd3, a: 4'h7, b: 4'h8, dly: 0, r: 4'hF, c: 1'b0};
    vecs[5] = '{id: 1, op: 2'd3, a: 4'h9, b: 4'h9, dly: 2, r: 4'h2, c: 1'b1};
    vecs[6] = '{id: 0, op: 2'd2, a: 4'hF, b: 4'hF, dly: 0, r: 4'h0, c: 1'b0};
    vecs[7] = '{id: 1, op: 2'd0, a: 4'h0, b: 4'hF, dly: 0, r: 4'h0, c: 1'b0};

    // Reset state
    @(posedge clk); #1;
    check("rst_gnt", 32'({gnt0, gnt1}), 32'(0));
    check("rst_valid", 32'(res_valid), 32'(0));
    check("rst_result", 32'(result), 32'(0));
    check("rst_carry_id", 32'({carry, res_id}), 32'(0));
    @(negedge clk) rst_n = 1'b1;

    // Contention from reset: order 0,1,0,1
    @(posedge clk); #1;
    res_ready = 1'b1;
    set_req(0, 2'd0, 4'hC, 4'h6);
    set_req(1, 2'd0, 4'h9, 4'hB);
    for (int i = 0; i < 4; i++) sb.push_back('{id: i[0], r: i[0] ? 4'h9 : 4'h4, c: 1'b0});
    for (int i = 0; i < 4; i++) wait_gnt(i[0]);
    req0 = 1'b0; req1 = 1'b0;
    drain();

    foreach (vecs[i])
      apply(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].dly, vecs[i].r, vecs[i].c);
    drain();

    // Backpressure with requester 0 waiting behind a stalled result
    @(posedge clk); #1;
    res_ready = 1'b0;
    set_req(1, 2'd2, 4'hA, 4'h5);
    sb.push_back('{id: 1, r: 4'hF, c: 1'b0});
    sb.push_back('{id: 0, r: 4'h6, c: 1'b0});
    wait_gnt(1);
    req1 = 1'b0;
    set_req(0, 2'd0, 4'hF, 4'h6);
    repeat (6) begin
      @(posedge clk); #1;
      check("bp_valid", 32'(res_valid), 32'(1));
      check("bp_result", 32'(result), 32'(4'hF));
      check("bp_no_gnt", 32'(gnt0 | gnt1), 32'(0));
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release", 32'(res_valid), 32'(0));
    check("bp_no_gnt_on_return", 32'(gnt0 | gnt1), 32'(0));
    @(posedge clk); #1;
    check("bp_waiter_gnt", 32'(gnt0), 32'(1));
    req0 = 1'b0;
    drain();

    // Reset during EXEC discards the operation; pointer returns to requester 1
    @(posedge clk); #1;
    set_req(0, 2'd3, 4'h3, 4'h4);
    wait_gnt(0);
    req0 = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 32'({gnt0, gnt1}), 32'(0));
    check("mid_rst_valid", 32'(res_valid), 32'(0));
    check("mid_rst_result", 32'(result), 32'(0));
    check("mid_rst_carry_id", 32'({carry, res_id}), 32'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_discarded", 32'(res_valid), 32'(0));
    set_req(0, 2'd1, 4'h1, 4'h2);
    set_req(1, 2'd3, 4'hE, 4'h3);
    sb.push_back('{id: 0, r: 4'h3, c: 1'b0});
    sb.push_back('{id: 1, r: 4'h1, c: 1'b1});
    wait_gnt(0);
    req0 = 1'b0;
    wait_gnt(1);
    req1 = 1'b0;
    drain();

    // Exhaustive through requester 1
    for (int op = 0; op < 4; op++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++) begin
          exp_t e;
          e = model(1'b1, 2'(op), W'(a), W'(b));
          apply(1'b1, 2'(op), W'(a), W'(b), 0, e.r, e.c);
        end
    drain();

`ifdef ALU_ARB_STATS_EN
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    check("cnt_rst", 32'({gnt_cnt0, gnt_cnt1}), 32'(0));
    rst_n = 1'b1;
    for (int i = 0; i < 300; i++) apply(1'b0, 2'd0, 4'h0, 4'h0, 0, 4'h0, 1'b0);
    @(posedge clk); #1;
    check("gnt_cnt0_sat", 32'(gnt_cnt0), 32'(255));
    check("gnt_cnt1_zero", 32'(gnt_cnt1), 32'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
